// File: rtl/frac_div_sched.sv
// frac_div_sched: super-period sequencer for the half-integer clock divider.
// Counts 0..L-1 (L = 2*act_int + act_half) and decodes the edge-event strobes
// for the downstream dual-edge output stage. Ratio updates are handshaken in
// and only take effect at a super-period boundary so the output cannot glitch.
module frac_div_sched #(
  parameter int INT_W    = 4,
  parameter int DEF_INT  = 3,
  parameter int DEF_HALF = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [INT_W-1:0] cfg_int,
  input  logic             cfg_half,
  output logic             cfg_err,
  output logic             rise_p,
  output logic             fall_p,
  output logic             rise_n,
  output logic             fall_n,
  output logic             sp_start,
  output logic             busy,
  output logic [INT_W-1:0] act_int,
  output logic             act_half
);

  localparam int CW = INT_W + 1;  // counter width, holds up to 2*max_int
  localparam int HW = INT_W + 2;  // width for 3*I+H and its half-point

  localparam logic [INT_W-1:0] MIN_INT     = INT_W'(2);
  localparam logic [INT_W-1:0] RST_INT     = INT_W'(DEF_INT);
  localparam logic             RST_HALF    = 1'(DEF_HALF);
  localparam logic [CW-1:0]    CNT_ZERO    = {CW{1'b0}};
  localparam logic [CW-1:0]    CNT_ONE     = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [HW-1:0]    H_ONE       = {{(HW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [INT_W-1:0]   act_int_q, act_int_d;
  logic               act_half_q, act_half_d;
  logic               pend_q, pend_d;
  logic [INT_W-1:0]   pend_int_q, pend_int_d;
  logic               pend_half_q, pend_half_d;
  logic               cfg_err_q, cfg_err_d;

  logic [CW-1:0]      len_s;
  logic               active_s;
  logic               wrap_s;
  logic               hs_s;
  logic               legal_s;

  logic [CW-1:0]      int_w_s;
  logic [HW-1:0]      cnt_h_s;
  logic [HW-1:0]      h_s;
  logic               rise_p_s, fall_p_s, rise_n_s, fall_n_s;

  assign len_s    = {act_int_q, 1'b0} + {{INT_W{1'b0}}, act_half_q};
  assign active_s = (state_q != ST_IDLE);
  assign wrap_s   = active_s && (cnt_q == (len_s - CNT_ONE));
  assign hs_s     = cfg_valid && !pend_q;
  assign legal_s  = (cfg_int >= MIN_INT);

  // Next-state logic: FSM, super-period counter, ratio handshake and apply-at-wrap
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    act_int_d   = act_int_q;
    act_half_d  = act_half_q;
    pend_d      = pend_q;
    pend_int_d  = pend_int_q;
    pend_half_d = pend_half_q;
    cfg_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = CNT_ZERO;
        if (en) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (wrap_s) begin
          cnt_d = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
        if (en) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (wrap_s) begin
          cnt_d = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
        if (en) begin
          state_d = ST_RUN;
        end else if (wrap_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase

    // A held ratio is promoted at the boundary; the slot then reopens.
    if (wrap_s && pend_q) begin
      act_int_d  = pend_int_q;
      act_half_d = pend_half_q;
      pend_d     = 1'b0;
    end else begin
      pend_d     = pend_q;
    end

    // pend_q is empty whenever hs_s is true, so this never collides with
    // the promotion above. In IDLE or at the wrap the new ratio goes
    // straight to the active registers for the next super-period.
    if (hs_s) begin
      if (legal_s) begin
        if (!active_s || wrap_s) begin
          act_int_d  = cfg_int;
          act_half_d = cfg_half;
        end else begin
          pend_d      = 1'b1;
          pend_int_d  = cfg_int;
          pend_half_d = cfg_half;
        end
      end else begin
        cfg_err_d = 1'b1;
      end
    end else begin
      cfg_err_d = 1'b0;
    end
  end

  // State and configuration registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= CNT_ZERO;
      act_int_q   <= RST_INT;
      act_half_q  <= RST_HALF;
      pend_q      <= 1'b0;
      pend_int_q  <= RST_INT;
      pend_half_q <= RST_HALF;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      act_int_q   <= act_int_d;
      act_half_q  <= act_half_d;
      pend_q      <= pend_d;
      pend_int_q  <= pend_int_d;
      pend_half_q <= pend_half_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign int_w_s = {1'b0, act_int_q};
  assign cnt_h_s = {1'b0, cnt_q};
  // 3*I + H: the half-cycle time of the second falling edge.
  assign h_s     = {2'b00, act_int_q} + {1'b0, act_int_q, 1'b0} + {{(HW-1){1'b0}}, act_half_q};

  // Edge-strobe decode from counter, state and active ratio only
  always_comb begin
    rise_p_s = 1'b0;
    fall_p_s = 1'b0;
    rise_n_s = 1'b0;
    fall_n_s = 1'b0;
    if (active_s) begin
      // Rise A at half-cycle 0.
      if (cnt_q == CNT_ZERO) begin
        rise_p_s = 1'b1;
      end else begin
        rise_p_s = 1'b0;
      end
      // Fall A at half-cycle I.
      if (!act_int_q[0]) begin
        if (cnt_q == (int_w_s >> 1)) begin
          fall_p_s = 1'b1;
        end else begin
          fall_p_s = 1'b0;
        end
      end else begin
        if (cnt_q == ((int_w_s + CNT_ONE) >> 1)) begin
          fall_n_s = 1'b1;
        end else begin
          fall_n_s = 1'b0;
        end
      end
      // Rise B at half-cycle 2I+H.
      if (!act_half_q) begin
        if (cnt_q == int_w_s) begin
          rise_p_s = 1'b1;
        end else begin
          rise_p_s = rise_p_s;
        end
      end else begin
        if (cnt_q == (int_w_s + CNT_ONE)) begin
          rise_n_s = 1'b1;
        end else begin
          rise_n_s = 1'b0;
        end
      end
      // Fall B at half-cycle 3I+H.
      if (!h_s[0]) begin
        if (cnt_h_s == (h_s >> 1)) begin
          fall_p_s = 1'b1;
        end else begin
          fall_p_s = fall_p_s;
        end
      end else begin
        if (cnt_h_s == ((h_s + H_ONE) >> 1)) begin
          fall_n_s = 1'b1;
        end else begin
          fall_n_s = fall_n_s;
        end
      end
    end else begin
      rise_p_s = 1'b0;
      fall_p_s = 1'b0;
      rise_n_s = 1'b0;
      fall_n_s = 1'b0;
    end
  end

  assign rise_p    = rise_p_s;
  assign fall_p    = fall_p_s;
  assign rise_n    = rise_n_s;
  assign fall_n    = fall_n_s;
  assign sp_start  = active_s && (cnt_q == CNT_ZERO);
  assign busy      = active_s;
  assign cfg_ready = !pend_q;
  assign cfg_err   = cfg_err_q;
  assign act_int   = act_int_q;
  assign act_half  = act_half_q;

endmodule

// File: tb/tb_frac_div_sched.sv
// Testbench for frac_div_sched: directed scenarios then random traffic,
// checked every cycle against a half-cycle edge-time reference model.
module tb_frac_div_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [3:0] cfg_int = 4'd0;
  logic       cfg_half = 1'b0;
  logic       cfg_err;
  logic       rise_p, fall_p, rise_n, fall_n;
  logic       sp_start, busy;
  logic [3:0] act_int;
  logic       act_half;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state: mode 0=idle 1=run 2=drain
  int m_mode, m_cnt, m_I, m_H, m_pend, m_pI, m_pH, m_err;

  frac_div_sched #(.INT_W(4), .DEF_INT(3), .DEF_HALF(1)) dut (
    .clk(clk), .rst(rst), .en(en),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_int(cfg_int), .cfg_half(cfg_half), .cfg_err(cfg_err),
    .rise_p(rise_p), .fall_p(fall_p), .rise_n(rise_n), .fall_n(fall_n),
    .sp_start(sp_start), .busy(busy),
    .act_int(act_int), .act_half(act_half)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output waveform: rise at half-cycle 0, fall at I, rise at 2I+H, fall at 3I+H.
  // An even half-cycle t is a posedge event in cycle t/2, an odd one a negedge
  // event in cycle (t+1)/2. Returns {rise_p, rise_n, fall_p, fall_n}.
  function automatic logic [3:0] exp_strobes(input int c, input int I, input int H);
    int t [4];
    logic [3:0] r;
    t[0] = 0; t[1] = I; t[2] = 2*I + H; t[3] = 3*I + H;
    r = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      if ((t[k] % 2) == 0 && t[k] / 2 == c) begin
        if (k % 2 == 0) r[3] = 1'b1; else r[1] = 1'b1;
      end
      if ((t[k] % 2) == 1 && (t[k] + 1) / 2 == c) begin
        if (k % 2 == 0) r[2] = 1'b1; else r[0] = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_I = 3; m_H = 1; m_pend = 0; m_pI = 0; m_pH = 0; m_err = 0;
  endtask

  task automatic model_clock(input int e, input int v, input int ci, input int ch, input int r);
    int len, wrap, hs, nI, nH, np, npI, npH;
    if (r != 0) begin
      model_reset();
      return;
    end
    len  = 2*m_I + m_H;
    wrap = (m_mode != 0 && m_cnt == len - 1) ? 1 : 0;
    hs   = (v != 0 && m_pend == 0) ? 1 : 0;
    nI = m_I; nH = m_H; np = m_pend; npI = m_pI; npH = m_pH;
    if (wrap != 0 && m_pend != 0) begin nI = m_pI; nH = m_pH; np = 0; end
    m_err = (hs != 0 && ci < 2) ? 1 : 0;
    if (hs != 0 && ci >= 2) begin
      if (m_mode == 0 || wrap != 0) begin nI = ci; nH = ch; end
      else begin np = 1; npI = ci; npH = ch; end
    end
    if (m_mode == 0) begin
      m_cnt = 0;
      m_mode = (e != 0) ? 1 : 0;
    end else begin
      m_cnt = (wrap != 0) ? 0 : m_cnt + 1;
      if (e != 0) m_mode = 1;
      else if (m_mode == 2 && wrap != 0) m_mode = 0;
      else m_mode = 2;
    end
    m_I = nI; m_H = nH; m_pend = np; m_pI = npI; m_pH = npH;
  endtask

  // One clock: drive inputs, check the current cycle, advance DUT and model.
  task automatic step(input logic e, input logic v, input logic [3:0] ci, input logic ch, input logic r);
    logic [3:0] es;
    en = e; cfg_valid = v; cfg_int = ci; cfg_half = ch; rst = r;
    es = (m_mode != 0) ? exp_strobes(m_cnt, m_I, m_H) : 4'b0000;
    chk("strobes", {28'd0, rise_p, rise_n, fall_p, fall_n}, {28'd0, es});
    chk("sp_start", {31'd0, sp_start}, (m_mode != 0 && m_cnt == 0) ? 32'd1 : 32'd0);
    chk("busy", {31'd0, busy}, (m_mode != 0) ? 32'd1 : 32'd0);
    chk("cfg_ready", {31'd0, cfg_ready}, (m_pend == 0) ? 32'd1 : 32'd0);
    chk("cfg_err", {31'd0, cfg_err}, 32'(m_err));
    chk("act_int", {28'd0, act_int}, 32'(m_I));
    chk("act_half", {31'd0, act_half}, 32'(m_H));
    @(posedge clk);
    model_clock(int'(e), int'(v), int'(ci), int'(ch), int'(r));
    #1;
  endtask

  task automatic idle_steps(input int n, input logic e);
    for (int i = 0; i < n; i++) step(e, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  // Keep running until the model counter reaches c in RUN (bounded).
  task automatic run_to_cnt(input int c);
    for (int i = 0; i < 64 && !(m_mode == 1 && m_cnt == c); i++) step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic stop_to_idle();
    for (int i = 0; i < 64 && m_mode != 0; i++) step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  initial begin
    logic e_r;
    // initial reset without checks
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    idle_steps(2, 1'b0);

    // default 3.5 running
    idle_steps(16, 1'b1);
    stop_to_idle();

    // program 4.0 in IDLE, then run
    step(1'b0, 1'b1, 4'd4, 1'b0, 1'b0);
    idle_steps(18, 1'b1);
    stop_to_idle();

    // back to 3.5, accept 5.0 mid super-period
    step(1'b0, 1'b1, 4'd3, 1'b1, 1'b0);
    idle_steps(3, 1'b1);
    run_to_cnt(2);
    step(1'b1, 1'b1, 4'd5, 1'b0, 1'b0);
    idle_steps(25, 1'b1);

    // illegal ratio while running
    step(1'b1, 1'b1, 4'd1, 1'b1, 1'b0);
    idle_steps(12, 1'b1);

    // return to 3.5 via pending, drop en at cnt 1
    step(1'b1, 1'b1, 4'd3, 1'b1, 1'b0);
    idle_steps(22, 1'b1);
    run_to_cnt(1);
    stop_to_idle();
    idle_steps(2, 1'b0);

    // reassert en during DRAIN
    idle_steps(2, 1'b1);
    run_to_cnt(1);
    idle_steps(2, 1'b0);
    idle_steps(12, 1'b1);

    // reset at cnt 3 with a pending ratio
    run_to_cnt(2);
    step(1'b1, 1'b1, 4'd6, 1'b0, 1'b0);
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
    idle_steps(3, 1'b0);

    // wrap-cycle bypass: handshake exactly at cnt == L-1
    idle_steps(2, 1'b1);
    run_to_cnt(6);
    step(1'b1, 1'b1, 4'd2, 1'b0, 1'b0);
    idle_steps(12, 1'b1);

    // random traffic
    e_r = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(19, 0) == 0) e_r = ~e_r;
      step(e_r,
           ($urandom_range(7, 0) == 0) ? 1'b1 : 1'b0,
           4'($urandom_range(9, 0)),
           1'($urandom_range(1, 0)),
           ($urandom_range(299, 0) == 0) ? 1'b1 : 1'b0);
    end
    stop_to_idle();
    idle_steps(2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
